// File: rtl/tnn_layer_sched.sv
// Time-multiplexes N_NEURONS ternary neurons onto one shared neuron datapath.
// Define TNN_SCHED_PERF_EN to add the saturating perf_samples completion counter.
module tnn_layer_sched #(
    parameter int N_NEURONS = 4,
    parameter int NEU_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [11:0]          in_data,
    output logic                 neu_issue,
    output logic [11:0]          neu_operands,
    input  logic                 neu_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_NEURONS-1:0] out_data,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_idx,
    input  logic [5:0]           cfg_mask,
    output logic                 cfg_err
`ifdef TNN_SCHED_PERF_EN
    ,
    output logic [15:0]          perf_samples
`endif
);
    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int TAG_D = (NEU_LAT > 0) ? NEU_LAT : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_NEURONS - 1);
    localparam logic [1:0]       LAST_DRAIN = 2'((NEU_LAT > 0) ? (NEU_LAT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        HOLD  = 2'b11
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [IDX_W-1:0]     k_r;
    logic [1:0]           drain_r;
    logic [11:0]          sample_r;
    logic [5:0]           mask_r [N_NEURONS];
    logic [N_NEURONS-1:0] acc_r;
    logic                 tag_vld_r [TAG_D];
    logic [IDX_W-1:0]     tag_idx_r [TAG_D];
    logic                 cfg_err_r;
    logic                 cap_vld_s;
    logic [IDX_W-1:0]     cap_idx_s;
    logic                 accept_s;
    logic                 cfg_ok_s;

    // Force every disabled 2-bit feature to zero.
    function automatic logic [11:0] apply_mask(input logic [11:0] data, input logic [5:0] mask);
        logic [11:0] res;
        res = 12'h000;
        for (int i = 0; i < 6; i++) begin
            res[2*i +: 2] = mask[i] ? data[2*i +: 2] : 2'b00;
        end
        return res;
    endfunction

    assign accept_s = in_valid && (state_r == IDLE);
    assign cfg_ok_s = cfg_we && (state_r == IDLE) && ({1'b0, cfg_idx} < 5'(N_NEURONS));
    assign out_data = acc_r;
    assign cfg_err  = cfg_err_r;

    // Next-state and handshake/issue outputs decoded from the state register.
    always_comb begin
        state_s      = state_r;
        in_ready     = 1'b0;
        neu_issue    = 1'b0;
        neu_operands = 12'h000;
        out_valid    = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                neu_issue    = 1'b1;
                neu_operands = apply_mask(sample_r, mask_r[k_r]);
                if (k_r == LAST_IDX) begin
                    if (NEU_LAT == 0) begin
                        state_s = HOLD;
                    end else begin
                        state_s = DRAIN;
                    end
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (drain_r == LAST_DRAIN) begin
                    state_s = HOLD;
                end else begin
                    state_s = DRAIN;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // With zero latency the result belongs to the neuron being issued right now.
    always_comb begin
        if (NEU_LAT == 0) begin
            cap_vld_s = neu_issue;
            cap_idx_s = k_r;
        end else begin
            cap_vld_s = tag_vld_r[TAG_D-1];
            cap_idx_s = tag_idx_r[TAG_D-1];
        end
    end

    // State register, neuron index, drain counter and sample capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            k_r      <= '0;
            drain_r  <= 2'd0;
            sample_r <= 12'h000;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                k_r      <= '0;
                sample_r <= in_data;
            end else if (neu_issue) begin
                k_r <= k_r + IDX_W'(1);
            end
            if (state_r == DRAIN) begin
                drain_r <= drain_r + 2'd1;
            end else begin
                drain_r <= 2'd0;
            end
        end
    end

    // Tag pipeline: remembers which neuron each in-flight result belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAG_D; i++) begin
                tag_vld_r[i] <= 1'b0;
                tag_idx_r[i] <= '0;
            end
        end else begin
            tag_vld_r[0] <= neu_issue;
            tag_idx_r[0] <= k_r;
            for (int i = 1; i < TAG_D; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_idx_r[i] <= tag_idx_r[i-1];
            end
        end
    end

    // Result accumulator; cleared on every accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (accept_s) begin
            acc_r <= '0;
        end else if (cap_vld_s) begin
            acc_r[cap_idx_s] <= neu_result;
        end
    end

    // Per-neuron feature masks and the rejected-write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mask_r[i] <= 6'h3F;
            end
            cfg_err_r <= 1'b0;
        end else begin
            if (cfg_ok_s) begin
                mask_r[cfg_idx[IDX_W-1:0]] <= cfg_mask;
            end
            cfg_err_r <= cfg_we && !cfg_ok_s;
        end
    end

`ifdef TNN_SCHED_PERF_EN
    logic [15:0] perf_r;
    assign perf_samples = perf_r;

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_r <= 16'h0000;
        end else if (out_valid && out_ready && (perf_r != 16'hFFFF)) begin
            perf_r <= perf_r + 16'h0001;
        end
    end
`endif

endmodule

// File: doc/tnn_layer_sched.md
TNN_LAYER_SCHED -- requirements
Module: tnn_layer_sched

Interface
REQ-001 Parameter N_NEURONS, default 4, number of neurons time-multiplexed onto one shared neuron datapath (range 1..16).
REQ-002 Parameter NEU_LAT, default 1, fixed neuron datapath latency in cycles (range 0..3).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  sample offered.
REQ-006 in_ready  output  1  block accepts sample this cycle.
REQ-007 in_data  input  12  six 2-bit features, a=[1:0], b=[3:2], c=[5:4], d=[7:6], e=[9:8], f=[11:10].
REQ-008 neu_issue  output  1  operands on neu_operands valid this cycle.
REQ-009 neu_operands  output  12  masked features to shared neuron, same packing as in_data.
REQ-010 neu_result  input  1  neuron decision bit, valid NEU_LAT cycles after its issue.
REQ-011 out_valid  output  1  result vector available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out_data  output  N_NEURONS  bit k = decision of neuron k.
REQ-014 cfg_we  input  1  mask write strobe.
REQ-015 cfg_idx  input  4  neuron index for write.
REQ-016 cfg_mask  input  6  per-feature enable; bit i gates feature i (a=bit0 .. f=bit5).
REQ-017 cfg_err  output  1  one-cycle pulse: rejected config write.

Function
REQ-018 FSM states IDLE, ISSUE, DRAIN, HOLD; in_ready=1 only in IDLE.
REQ-019 IDLE: in_valid&in_ready latches in_data into sample register, clears out_data accumulator, k=0, next ISSUE.
REQ-020 ISSUE: one neuron per cycle; neu_issue=1, neu_operands = sample with each disabled feature forced to 2'b00 per mask[k]; k increments; after k=N_NEURONS-1 go DRAIN.
REQ-021 Result of issue in cycle t sampled at edge ending cycle t+NEU_LAT and written to out_data bit of its index; index tracked by NEU_LAT-deep tag pipeline.
REQ-022 NEU_LAT=0: DRAIN skipped, ISSUE goes directly to HOLD; results captured same cycle as issue.
REQ-023 DRAIN lasts exactly NEU_LAT cycles, neu_issue=0, then HOLD.
REQ-024 Latency in_valid accept to out_valid = N_NEURONS+NEU_LAT+1 cycles.
REQ-025 HOLD: out_valid=1, out_data stable; out_valid&out_ready -> IDLE next cycle; no back-to-back accept in same cycle.
REQ-026 neu_operands = 0 whenever neu_issue=0.
REQ-027 cfg_we in IDLE with cfg_idx<N_NEURONS writes mask[cfg_idx]; effective for next accepted sample.
REQ-028 cfg_we outside IDLE or cfg_idx>=N_NEURONS: ignored, cfg_err=1 next cycle.
REQ-029 cfg_we and sample accept in the same IDLE cycle: write applies, sample uses new mask.

Reset
REQ-030 rst wins over all inputs; next state IDLE, k=0, tag pipeline cleared.
REQ-031 Post-reset outputs: in_ready=1, out_valid=0, out_data=0, neu_issue=0, neu_operands=0, cfg_err=0.
REQ-032 All masks reset to 6'h3F.
REQ-033 rst mid-ISSUE/DRAIN/HOLD discards sample and partial results; late neu_result ignored.

Configuration
REQ-034 Macro TNN_SCHED_PERF_EN defined: adds output perf_samples 16 bits, counts completed out handshakes, saturates at 16'hFFFF, reset to 0.
REQ-035 Macro undefined: port perf_samples and counter absent; all other behaviour identical.

Verification
REQ-036 Reset, N=4, LAT=1, in_data=12'hFFF, neu_result=1 -> neu_issue high 4 cycles, out_valid at cycle 6 after accept, out_data=4'hF.
REQ-037 mask[2]=6'b000001, in_data=12'hABC -> third issue neu_operands=12'h000, others 12'hABC.
REQ-038 neu_result driven = issue index odd, LAT=2 -> out_data=4'b1010; LAT=0 -> same value, latency 5.
REQ-039 out_ready low 10 cycles in HOLD -> out_valid,out_data stable, in_ready=0, in_valid ignored.
REQ-040 cfg_we during ISSUE and cfg_idx=7 in IDLE (N=4) -> cfg_err pulses, masks unchanged.
REQ-041 rst asserted in DRAIN -> next cycle in_ready=1, out_valid=0; next sample results uncorrupted; with TNN_SCHED_PERF_EN perf_samples=0.
